lstm_seq_cell: RTL and testbench
================================

Name: lstm_seq_cell

Overview:
- Time-multiplexed, sequence-capable LSTM cell for the CRNN recurrent stage.
- Accepts one input vector x_t per handshake and keeps h/c state internally across timesteps.
- Computes all four gates with four MAC units, one weight column per cycle, instead of full combinational matrix multipliers.
- Returns h_t/c_t on a valid/ready output port. Operates on Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH signed fixed point.

Parameters:
- M, 16, hidden size (rows of h, c, gates)
- N, 32, input vector length
- DATA_WIDTH, 16, signed element width
- FRACT_WIDTH, 8, fractional bits
- ACC_WIDTH, 2*DATA_WIDTH+8, accumulator width. Must be ≥ 2*DATA_WIDTH+clog2(N+M+2).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  x_in valid
- in_ready  out  1  high only in IDLE
- in_first  in  1  sampled with x_in; zeroes h/c state before this step
- x_in  in  N*DATA_WIDTH  input vector; element k at bits [k*DW +: DW]
- w_x  in  4*M*N*DATA_WIDTH  input weights. Gate order i,f,g,o (gate 0 in LSBs), row-major per gate. Static while busy.
- w_h  in  4*M*M*DATA_WIDTH  recurrent weights, same ordering
- b_x  in  4*M*DATA_WIDTH  input biases, gate-major
- b_h  in  4*M*DATA_WIDTH  recurrent biases
- out_valid  out  1  h_out/c_out valid
- out_ready  in  1  consumer ready
- h_out  out  M*DATA_WIDTH  h_t
- c_out  out  M*DATA_WIDTH  c_t
- busy  out  1  high in any state other than IDLE

Behaviour:
- States:
  - IDLE: in_ready=1.
  - MAC: per row r, k=0..N+M-1.
  - ACT: 1 cycle per row.
  - COMMIT: 1 cycle.
  - OUT: out_valid=1.
- Reset (async): state=IDLE, r=k=0, accumulators=0, h/c state=0, h_out=c_out=0, out_valid=0.
- Accept: in IDLE, in_valid && in_ready.
  - Register x_in.
  - If in_first, clear h_state and c_state on the same edge.
  - Clear the accumulators and go to MAC with r=0, k=0.
- MAC: each cycle, acc[g] += W[g][r][k]*v[k] for the 4 gates.
  - v[k]=x_reg[k] for k<N, else h_state[k-N].
  - The full 2*DW product is sign-extended to ACC_WIDTH.
  - At k=N+M-1, go to ACT.
- ACT for row r:
  - pre[g] = sat_DW((acc[g] + (b_x[g][r]<<<FW) + (b_h[g][r]<<<FW)) >>> FW). The shift is arithmetic (truncation toward -inf).
  - i,f,o = hsig(pre) = clamp((pre>>>2) + 0.5, 0, 1.0).
  - g = htanh(pre) = clamp(pre, -1.0, 1.0).
  - Elementwise product a⊙b = sat_DW((a*b)>>>FW).
  - c_next[r] = sat_DW(f⊙c_state[r] + i⊙g).
  - h_next[r] = o⊙htanh(c_next[r]).
  - Then clear the accumulators. If r<M-1, set r++, k=0 and go to MAC; else go to COMMIT.
  - h_state is not modified until COMMIT, so all rows use h_{t-1}.
- COMMIT: h_state/c_state ← h_next/c_next; h_out/c_out ← same; go to OUT.
- OUT: out_valid=1 until out_valid && out_ready, then IDLE.
  - h_out/c_out stay stable while out_valid is asserted and hold their value after the handshake.
- Latency: out_valid rises M*(N+M+1)+1 cycles after the accept edge.
- Throughput: one step per M*(N+M+1)+2 cycles minimum, including the OUT handshake cycle.
- in_valid while busy: ignored (no capture); in_ready stays low.
- Back-to-back operation: a new step can be accepted in the first IDLE cycle after the OUT handshake.
- Reset mid-operation: immediate abort, all state zero, no out_valid pulse.
- Saturation: sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1]; it never wraps.

Test Plan (M=2, N=3, DW=16, FW=8; 1.0=256):
- Reset, then all weights/biases 0, x arbitrary, in_first=1 -> out_valid at cycle 13 after accept; h_out=0, c_out=0 (i=f=o=128, g=0).
- As above, but b_x[g-gate] rows = 256, in_first=1 -> c_out={128,128}, h_out={64,64}. Next step with in_first=0 -> c_out={192,192}, h_out={96,96}.
- Saturation: w_x[i][*][*]=0x7FFF, x=0x7FFF, b_x[g]=256 -> pre_i saturates, i=256; c_out=256, h_out=128; no wrap.
- Backpressure: out_ready=0 for 10 cycles -> out_valid held, in_ready=0, h_out/c_out constant, a pulsed in_valid is ignored. out_ready=1 -> handshake, in_ready=1 on the next cycle.
- Reset asserted at MAC cycle 5 -> out_valid=0, h_out=c_out=0, in_ready=1. A subsequent step with in_first=0 behaves as from zero state.
- Recurrence check: w_h[f] identity, x=0, after the step-2 state above -> the computed values match the golden fixed-point model bit-exactly.

Source files
------------

// File: rtl/lstm_seq_cell.sv
// -----------------------------------------------------------------------------
// lstm_seq_cell
//   Time-multiplexed LSTM cell for the CRNN recurrent stage. One input vector
//   x_t is accepted per handshake. h/c state is kept internally across
//   timesteps. For each hidden row, four MAC units (gates i, f, g, o) walk one
//   weight column per cycle over [x_t ; h_{t-1}]. A single activation cycle per
//   row then produces c_t[r] and h_t[r]. Arithmetic is signed fixed point with
//   FRACT_WIDTH fractional bits.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_ready is high only when idle
//   in_first             sampled with x_in; zeroes h/c state before this step
//   x_in                 input vector, element k at [k*DW +: DW]
//   w_x, w_h             input / recurrent weights, gate-major (i,f,g,o),
//                        row-major per gate; must be static while busy
//   b_x, b_h             input / recurrent biases, gate-major
//   out_valid/out_ready  output handshake for h_out/c_out
//   h_out, c_out         h_t and c_t, held after the handshake
//   busy                 high whenever the cell is not idle
// -----------------------------------------------------------------------------
module lstm_seq_cell #(
  parameter int M           = 16,
  parameter int N           = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int FRACT_WIDTH = 8,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic [N*DATA_WIDTH-1:0]        x_in,
  input  logic [4*M*N*DATA_WIDTH-1:0]    w_x,
  input  logic [4*M*M*DATA_WIDTH-1:0]    w_h,
  input  logic [4*M*DATA_WIDTH-1:0]      b_x,
  input  logic [4*M*DATA_WIDTH-1:0]      b_h,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [M*DATA_WIDTH-1:0]        h_out,
  output logic [M*DATA_WIDTH-1:0]        c_out,
  output logic                           busy
);

  localparam int DW     = DATA_WIDTH;
  localparam int FW     = FRACT_WIDTH;
  localparam int K_LAST = N + M - 1;
  localparam int KW     = (N + M > 1) ? $clog2(N + M) : 1;
  localparam int RW     = (M > 1) ? $clog2(M) : 1;

  localparam logic signed [DW-1:0] ONE     = DW'(1 << FW);
  localparam logic signed [DW-1:0] NEG_ONE = -ONE;
  localparam logic signed [DW-1:0] HALF    = DW'(1 << (FW - 1));
  localparam logic signed [DW-1:0] ZERO    = '0;
  localparam logic signed [DW-1:0] SMAX    = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN    = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_SMAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_SMIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_ACT, S_COMMIT, S_OUT} state_t;

  state_t                   state, state_nx;
  logic [RW-1:0]            r;
  logic [KW-1:0]            k;
  logic signed [DW-1:0]     x_reg   [N];
  logic signed [DW-1:0]     h_state [M];
  logic signed [DW-1:0]     c_state [M];
  logic signed [DW-1:0]     h_next  [M];
  logic signed [DW-1:0]     c_next  [M];
  logic signed [ACC_WIDTH-1:0] acc  [4];

  // ---------------------------------------------------------------------------
  // Fixed-point helpers
  // ---------------------------------------------------------------------------
  // Clamp a wide signed value into DW bits; never wraps.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_WIDTH-1:0] v);
    if (v > ACC_SMAX)      return SMAX;
    else if (v < ACC_SMIN) return SMIN;
    else                   return v[DW-1:0];
  endfunction

  // Elementwise product: sat((a*b) >>> FW), the shift floors toward -inf.
  function automatic logic signed [DW-1:0] fx_mul(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0]      p;
    logic signed [ACC_WIDTH-1:0] t;
    p = (2*DW)'(a) * (2*DW)'(b);
    t = ACC_WIDTH'(p);
    return sat_dw(t >>> FW);
  endfunction

  // Hard sigmoid: clamp(pre/4 + 0.5, 0, 1.0).
  function automatic logic signed [DW-1:0] hsig(input logic signed [DW-1:0] pre);
    logic signed [DW-1:0] t;
    t = (pre >>> 2) + HALF;
    if (t < ZERO)     return ZERO;
    else if (t > ONE) return ONE;
    else              return t;
  endfunction

  // Hard tanh: clamp(pre, -1.0, 1.0).
  function automatic logic signed [DW-1:0] htanh(input logic signed [DW-1:0] pre);
    if (pre < NEG_ONE)  return NEG_ONE;
    else if (pre > ONE) return ONE;
    else                return pre;
  endfunction

  // ---------------------------------------------------------------------------
  // Control FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = S_MAC;
      end
      S_MAC:    if (k == KW'(K_LAST)) state_nx = S_ACT;
      S_ACT:    state_nx = (r == RW'(M - 1)) ? S_COMMIT : S_MAC;
      S_COMMIT: state_nx = S_OUT;
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MAC operand selection: column k of row r for each gate, against v[k]
  // (x for k<N, previous h otherwise). Equality muxes keep every array index
  // a constant after loop unrolling.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0]   v_cur;
  logic signed [DW-1:0]   w_cur [4];
  logic signed [2*DW-1:0] prod  [4];

  always_comb begin
    v_cur = '0;
    for (int j = 0; j < N; j++) if (int'(k) == j)     v_cur = x_reg[j];
    for (int j = 0; j < M; j++) if (int'(k) == N + j) v_cur = h_state[j];
    for (int g = 0; g < 4; g++) begin
      w_cur[g] = '0;
      for (int rr = 0; rr < M; rr++) begin
        for (int j = 0; j < N; j++)
          if (int'(r) == rr && int'(k) == j)
            w_cur[g] = w_x[((g*M + rr)*N + j)*DW +: DW];
        for (int j = 0; j < M; j++)
          if (int'(r) == rr && int'(k) == N + j)
            w_cur[g] = w_h[((g*M + rr)*M + j)*DW +: DW];
      end
      prod[g] = (2*DW)'(w_cur[g]) * (2*DW)'(v_cur);
    end
  end

  // ---------------------------------------------------------------------------
  // Activation path for row r: bias add, rescale, gate nonlinearities, c/h.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] pre [4];
  logic signed [DW-1:0] gate_i, gate_f, gate_g, gate_o;
  logic signed [DW-1:0] c_cur, c_new, h_new;

  always_comb begin : act_path
    logic signed [ACC_WIDTH-1:0] bx, bh, sum, csum;
    for (int g = 0; g < 4; g++) begin
      bx = '0;
      bh = '0;
      for (int rr = 0; rr < M; rr++) begin
        if (int'(r) == rr) begin
          bx = ACC_WIDTH'($signed(b_x[(g*M + rr)*DW +: DW]));
          bh = ACC_WIDTH'($signed(b_h[(g*M + rr)*DW +: DW]));
        end
      end
      // Biases are aligned to the accumulator's 2*FW fractional bits.
      sum    = acc[g] + (bx <<< FW) + (bh <<< FW);
      pre[g] = sat_dw(sum >>> FW);
    end
    c_cur = '0;
    for (int rr = 0; rr < M; rr++) if (int'(r) == rr) c_cur = c_state[rr];
    gate_i = hsig(pre[0]);
    gate_f = hsig(pre[1]);
    gate_g = htanh(pre[2]);
    gate_o = hsig(pre[3]);
    csum   = ACC_WIDTH'(fx_mul(gate_f, c_cur)) + ACC_WIDTH'(fx_mul(gate_i, gate_g));
    c_new  = sat_dw(csum);
    h_new  = fx_mul(gate_o, htanh(c_new));
  end

  // ---------------------------------------------------------------------------
  // Datapath and state registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      r     <= '0;
      k     <= '0;
      h_out <= '0;
      c_out <= '0;
      for (int g = 0; g < 4; g++) acc[g] <= '0;
      // NOTE: these arrays are a few registers, not RAM, so they are reset
      // explicitly; an abort must leave no stale recurrent state behind.
      for (int j = 0; j < N; j++) x_reg[j] <= '0;
      for (int j = 0; j < M; j++) begin
        h_state[j] <= '0;
        c_state[j] <= '0;
        h_next[j]  <= '0;
        c_next[j]  <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int j = 0; j < N; j++) x_reg[j] <= x_in[j*DW +: DW];
            if (in_first) begin
              for (int j = 0; j < M; j++) begin
                h_state[j] <= '0;
                c_state[j] <= '0;
              end
            end
            for (int g = 0; g < 4; g++) acc[g] <= '0;
            r <= '0;
            k <= '0;
          end
        end
        S_MAC: begin
          for (int g = 0; g < 4; g++) acc[g] <= acc[g] + ACC_WIDTH'(prod[g]);
          k <= (k == KW'(K_LAST)) ? '0 : k + 1'b1;
        end
        S_ACT: begin
          for (int j = 0; j < M; j++) begin
            if (int'(r) == j) begin
              h_next[j] <= h_new;
              c_next[j] <= c_new;
            end
          end
          for (int g = 0; g < 4; g++) acc[g] <= '0;
          k <= '0;
          if (r != RW'(M - 1)) r <= r + 1'b1;
        end
        S_COMMIT: begin
          // h_state only changes here, so every row of a step saw h_{t-1}.
          for (int j = 0; j < M; j++) begin
            h_state[j]         <= h_next[j];
            c_state[j]         <= c_next[j];
            h_out[j*DW +: DW]  <= h_next[j];
            c_out[j*DW +: DW]  <= c_next[j];
          end
          r <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lstm_seq_cell.sv
// -----------------------------------------------------------------------------
// tb_lstm_seq_cell
//   Directed self-checking bench for lstm_seq_cell with M=2, N=3, Q8.8.
//   Expected values are hand-computed fixed-point results (1.0 = 256).
// -----------------------------------------------------------------------------
module tb_lstm_seq_cell;

  localparam int M   = 2;
  localparam int N   = 3;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int AW  = 2*DW + 8;
  localparam int LAT = M*(N+M+1) + 1;  // 13 cycles from accept edge
  localparam int G_I = 0;
  localparam int G_F = 1;
  localparam int G_G = 2;
  localparam int G_O = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_first;
  logic [N*DW-1:0]        x_in;
  logic [4*M*N*DW-1:0]    w_x;
  logic [4*M*M*DW-1:0]    w_h;
  logic [4*M*DW-1:0]      b_x;
  logic [4*M*DW-1:0]      b_h;
  logic                   out_valid;
  logic                   out_ready;
  logic [M*DW-1:0]        h_out;
  logic [M*DW-1:0]        c_out;
  logic                   busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lstm_seq_cell #(
    .M(M), .N(N), .DATA_WIDTH(DW), .FRACT_WIDTH(FW), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .x_in(x_in),
    .w_x(w_x), .w_h(w_h), .b_x(b_x), .b_h(b_h),
    .out_valid(out_valid), .out_ready(out_ready),
    .h_out(h_out), .c_out(c_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wx(input int g, input int r, input int k, input logic [DW-1:0] v);
    w_x[((g*M + r)*N + k)*DW +: DW] = v;
  endtask

  task automatic set_wh(input int g, input int r, input int k, input logic [DW-1:0] v);
    w_h[((g*M + r)*M + k)*DW +: DW] = v;
  endtask

  task automatic set_bx(input int g, input int r, input logic [DW-1:0] v);
    b_x[(g*M + r)*DW +: DW] = v;
  endtask

  task automatic set_bh(input int g, input int r, input logic [DW-1:0] v);
    b_h[(g*M + r)*DW +: DW] = v;
  endtask

  // Accept one vector, wait (bounded) for out_valid, check latency and result.
  task automatic run_step(input string tag, input logic [N*DW-1:0] x, input logic first,
                          input logic [31:0] exp_h, input logic [31:0] exp_c);
    int lat;
    x_in     = x;
    in_first = first;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_h_out"}, h_out, exp_h);
    check({tag, "_c_out"}, c_out, exp_c);
  endtask

  // Complete the output handshake (out_ready assumed high).
  task automatic handshake(input string tag);
    tick();
    check({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] h_hold;
    logic [31:0] c_hold;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    x_in      = '0;
    w_x       = '0;
    w_h       = '0;
    b_x       = '0;
    b_h       = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_h_out", h_out, 32'h0);
    check("rst_c_out", c_out, 32'h0);
    rst = 1'b0;
    tick();

    // All-zero parameters: i=f=o=0.5, g=0 -> c=h=0
    run_step("zero", 48'h0123_4567_89AB, 1'b1, 32'h0000_0000, 32'h0000_0000);
    handshake("zero");

    // g-gate bias 1.0: c = 0.5*1.0 = 128, h = 0.5*0.5 = 64
    set_bx(G_G, 0, 16'd256);
    set_bx(G_G, 1, 16'd256);
    run_step("bias1", 48'h0, 1'b1, 32'h0040_0040, 32'h0080_0080);
    handshake("bias1");
    // Carry state: c = 0.5*128 + 128 = 192, h = 0.5*192 = 96
    run_step("bias2", 48'h0, 1'b0, 32'h0060_0060, 32'h00C0_00C0);
    handshake("bias2");

    // Recurrence: w_h[f] identity, b_h[o] = -1 LSB, x = 0, from h=96, c=192.
    // pre_f = 96 -> f = 24+128 = 152; pre_o = -1 -> o = floor(-1/4)+128 = 127.
    // c = (152*192)>>8 + 128 = 114+128 = 242; h = (127*242)>>8 = 120.
    set_wh(G_F, 0, 0, 16'd256);
    set_wh(G_F, 1, 1, 16'd256);
    set_bh(G_O, 0, 16'hFFFF);
    set_bh(G_O, 1, 16'hFFFF);
    run_step("recur", 48'h0, 1'b0, 32'h0078_0078, 32'h00F2_00F2);
    handshake("recur");
    w_h = '0;
    b_h = '0;

    // Saturation: i-gate pre-activation overflows DW, must clamp (i=1.0).
    // c = 1.0*1.0 = 256, h = 0.5*1.0 = 128
    for (int r = 0; r < M; r++)
      for (int k = 0; k < N; k++)
        set_wx(G_I, r, k, 16'h7FFF);
    run_step("sat", {3{16'h7FFF}}, 1'b1, 32'h0080_0080, 32'h0100_0100);
    handshake("sat");

    // Backpressure: hold out_ready low for 10 cycles with a stray in_valid pulse.
    out_ready = 1'b0;
    run_step("bp", {3{16'h7FFF}}, 1'b1, 32'h0080_0080, 32'h0100_0100);
    h_hold = h_out;
    c_hold = c_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      in_first = (i == 3);
      x_in     = '0;
      tick();
      check("bp_out_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      check("bp_h_stable", h_out, h_hold);
      check("bp_c_stable", c_out, c_hold);
    end
    in_valid  = 1'b0;
    in_first  = 1'b0;
    out_ready = 1'b1;
    handshake("bp");
    check("bp_not_busy", 32'(busy), 32'd0);
    check("bp_h_after", h_out, 32'h0080_0080);
    check("bp_c_after", c_out, 32'h0100_0100);

    // Reset in MAC cycle 5 of a step, then a step with in_first=0 from zero state.
    w_x      = '0;
    x_in     = '0;
    in_first = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_h_out", h_out, 32'h0);
    check("abort_c_out", c_out, 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    check("abort_no_pulse", 32'(out_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_idle", 32'(in_ready), 32'd1);
    run_step("post_abort", 48'h0, 1'b0, 32'h0040_0040, 32'h0080_0080);
    handshake("post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
